ex_mem_stage: RTL

- EX/MEM boundary stage directly downstream of the ALU.
- Consumes ALU result and flags plus EX-stage control, resolves conditional branches from z_flag/n_flag, and detects signed-overflow traps from v_flag.
- Registers everything into the EX/MEM pipeline latch, with stall, flush and halt handling, and feeds the memory stage and the PC-select logic.

---
 rtl/cpu_types_pkg.sv | 70 +++++++
 rtl/branch_resolve.sv | 43 ++++
 rtl/ex_mem_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module   : cpu_types_pkg
// Purpose  : Shared CPU datapath types. Provides the datapath word type, the
//            branch-type encoding, the EX/MEM stage FSM state encoding and
//            the packed EX/MEM latch record, plus small helpers for the latch
//            bubble and the branch offset.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Conditional-branch kind carried down from decode.
  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_EQ   = 2'd1,
    BR_NE   = 2'd2,
    BR_LTZ  = 2'd3
  } branch_t;

  // EX/MEM stage FSM encodings. The plain constants are what the stage
  // compares against; the enum gives the same values a readable type.
  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_EXC    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  typedef enum logic [1:0] {
    RUN    = S_RUN,
    EXC    = S_EXC,
    HALTED = S_HALTED
  } stage_state_t;

  // Contents of the EX/MEM pipeline latch.
  typedef struct packed {
    logic        valid;
    logic        regwr;
    logic        memrd;
    logic        memwr;
    logic        halt;
    logic [4:0]  wsel;
    word_t       alu_out;
    word_t       stdata;
  } ex_mem_t;

  // A bubble clears every control bit but leaves the data fields as they
  // were, so the data registers only toggle when real work is latched.
  function automatic ex_mem_t make_bubble(input ex_mem_t cur);
    ex_mem_t b;
    b       = cur;
    b.valid = 1'b0;
    b.regwr = 1'b0;
    b.memrd = 1'b0;
    b.memwr = 1'b0;
    b.halt  = 1'b0;
    return b;
  endfunction

  // Word-aligned branch displacement: immediate scaled by four.
  function automatic word_t branch_offset(input word_t imm);
    return {imm[WORD_W-3:0], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_resolve.sv
// ============================================================================
// Module   : branch_resolve
// Purpose  : Combinational conditional-branch resolution from the ALU flags.
//            BR_EQ is taken on zero, BR_NE on non-zero, BR_LTZ on negative.
//            The target is pc4 + (imm << 2), wrapping modulo 2^32.
//            Instruction validity is not considered here; the caller gates.
// Ports    : br     in  branch kind
//            z, n   in  ALU zero / negative flags
//            pc4    in  PC+4 of the instruction
//            imm    in  sign-extended immediate
//            taken  out branch condition satisfied
//            target out branch destination
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve
  import cpu_types_pkg::*;
(
  input  branch_t br,
  input  logic    z,
  input  logic    n,
  input  word_t   pc4,
  input  word_t   imm,
  output logic    taken,
  output word_t   target
);

  always_comb begin
    taken = 1'b0;
    case (br)
      BR_EQ:   taken = z;
      BR_NE:   taken = ~z;
      BR_LTZ:  taken = n;
      default: taken = 1'b0;
    endcase
  end

  assign target = pc4 + branch_offset(imm);

endmodule

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// ============================================================================
// Module   : ex_mem_stage
// Purpose  : EX/MEM pipeline boundary directly after the ALU. Resolves
//            conditional branches, optionally raises a signed-overflow trap,
//            and registers the EX results/controls into the EX/MEM latch with
//            stall, flush and halt handling.
// Config   : `OVF_TRAP_EN - when defined, trapping ADD/SUB with alu_v set
//            raise exc_ov, record epc and redirect to EXC_VECTOR through a
//            one-cycle EXC state. When undefined, alu_v/ex_trap_ov are
//            ignored, the FSM is RUN/HALTED only and exc_ov/epc read 0.
// Ports    : CLK, nRST                 clock, async active-low reset
//            ex_valid                  EX holds a real instruction
//            alu_out, alu_z/n/v        ALU result and flags
//            ex_pc4, ex_imm            PC+4 and sign-extended immediate
//            ex_br                     branch kind (branch_t encoding)
//            ex_trap_ov                instruction traps on overflow
//            ex_regwr/memrd/memwr/halt EX control bits
//            ex_wsel, ex_stdata        destination reg, store data
//            mem_stall                 freeze the latch
//            flush                     squash the EX instruction
//            mem_*                     latched controls and data
//            br_taken, br_target       registered PC redirect
//            exc_ov, epc               overflow pulse, faulting PC
//            ex_stall                  backpressure to EX/ID
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_stage
  import cpu_types_pkg::*;
#(
  parameter logic [WORD_W-1:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ex_valid,
  input  logic [WORD_W-1:0] alu_out,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_v,
  input  logic [WORD_W-1:0] ex_pc4,
  input  logic [WORD_W-1:0] ex_imm,
  input  logic [1:0]        ex_br,
  input  logic              ex_trap_ov,
  input  logic              ex_regwr,
  input  logic              ex_memrd,
  input  logic              ex_memwr,
  input  logic              ex_halt,
  input  logic [4:0]        ex_wsel,
  input  logic [WORD_W-1:0] ex_stdata,
  input  logic              mem_stall,
  input  logic              flush,
  output logic              mem_valid,
  output logic              mem_regwr,
  output logic              mem_memrd,
  output logic              mem_memwr,
  output logic              mem_halt,
  output logic [WORD_W-1:0] mem_alu_out,
  output logic [WORD_W-1:0] mem_stdata,
  output logic [4:0]        mem_wsel,
  output logic              br_taken,
  output logic [WORD_W-1:0] br_target,
  output logic              exc_ov,
  output logic [WORD_W-1:0] epc,
  output logic              ex_stall
);

  logic [1:0] state;
  ex_mem_t    lat;
  logic       br_taken_q;
  word_t      br_target_q;

  branch_t    br_type;
  logic       res_taken;
  word_t      res_target;
  logic       trap;
  logic       advance;

  assign br_type = branch_t'(ex_br);

  branch_resolve u_branch_resolve (
    .br     (br_type),
    .z      (alu_z),
    .n      (alu_n),
    .pc4    (ex_pc4),
    .imm    (ex_imm),
    .taken  (res_taken),
    .target (res_target)
  );

  // A RUN-state edge that is allowed to move the latch.
  assign advance = (state == S_RUN) && !mem_stall;

`ifdef OVF_TRAP_EN
  // Flush outranks the trap: a squashed instruction never faults.
  assign trap = ex_valid & ex_trap_ov & alu_v & ~flush;
`else
  assign trap = 1'b0;
  logic unused_ovf;
  assign unused_ovf = alu_v ^ ex_trap_ov;
`endif

  // --------------------------------------------------------------------------
  // Pipeline latch, redirect registers and stage FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= S_RUN;
      lat         <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (!mem_stall) begin
            if (flush || trap) begin
              // Squash or fault: the instruction never reaches MEM. A trap
              // also redirects fetch to the exception vector.
              lat        <= make_bubble(lat);
              br_taken_q <= trap;
              if (trap) begin
                br_target_q <= EXC_VECTOR;
                state       <= S_EXC;
              end
            end else begin
              lat <= '{valid:   ex_valid,
                       regwr:   ex_valid & ex_regwr,
                       memrd:   ex_valid & ex_memrd,
                       memwr:   ex_valid & ex_memwr,
                       halt:    ex_valid & ex_halt,
                       wsel:    ex_wsel,
                       alu_out: alu_out,
                       stdata:  ex_stdata};
              br_taken_q <= ex_valid & res_taken;
              if (ex_valid && res_taken) begin
                br_target_q <= res_target;
              end
              if (ex_valid && ex_halt) begin
                state <= S_HALTED;
              end
            end
          end
        end
`ifdef OVF_TRAP_EN
        S_EXC: begin
          // One recovery cycle: whatever EX holds is the wrong-path
          // instruction behind the fault, so it is discarded.
          if (!mem_stall) begin
            lat        <= make_bubble(lat);
            br_taken_q <= 1'b0;
            state      <= S_RUN;
          end
        end
`endif
        default: begin
          // HALTED: frozen until reset.
        end
      endcase
    end
  end

`ifdef OVF_TRAP_EN
  logic  exc_ov_q;
  word_t epc_q;

  // exc_ov is a strict one-cycle pulse, so it is cleared on every edge that
  // is not itself a trapping edge, even while the latch is stalled.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      exc_ov_q <= 1'b0;
      epc_q    <= '0;
    end else begin
      exc_ov_q <= advance & trap;
      if (advance && trap) begin
        epc_q <= ex_pc4 - word_t'(4);
      end
    end
  end

  assign exc_ov = exc_ov_q;
  assign epc    = epc_q;
`else
  assign exc_ov = 1'b0;
  assign epc    = '0;
`endif

  assign mem_valid   = lat.valid;
  assign mem_regwr   = lat.regwr;
  assign mem_memrd   = lat.memrd;
  assign mem_memwr   = lat.memwr;
  assign mem_halt    = lat.halt;
  assign mem_wsel    = lat.wsel;
  assign mem_alu_out = lat.alu_out;
  assign mem_stdata  = lat.stdata;
  assign br_taken    = br_taken_q;
  assign br_target   = br_target_q;

  assign ex_stall = mem_stall | (state == S_EXC);

endmodule

`default_nettype wire
